pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_goal_fsm.sv | 72 +++++++
 rtl/pong_renderer.sv | 151 +++++++++++++++
 tb/tb_pong_renderer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong constants: VGA timing offsets, coordinate widths, goal FSM encoding
// and the per-frame object position payload.
package pong_pkg;

  localparam int unsigned H_OFFSET    = 144;
  localparam int unsigned V_OFFSET    = 35;
  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;

  localparam int unsigned CNT_W       = 12;
  localparam int unsigned COORD_W     = 13;
  localparam int unsigned FLASH_CNT_W = 8;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic {
    PLAY  = 1'b0,
    FLASH = 1'b1
  } goal_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] paddle_1;
    logic [CNT_W-1:0] paddle_2;
    logic [CNT_W-1:0] ball_x;
    logic [CNT_W-1:0] ball_y;
  } positions_t;

endpackage

// File: rtl/pong_goal_fsm.sv
// Goal flash controller: holds FLASH for a number of frame boundaries after each goal,
// latching which half of the screen should flash.
module pong_goal_fsm
  import pong_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        goal_pulse,
  input  logic        goal_side,
  output goal_state_t state,
  output logic        flash_side,
  output logic        flashing
);

  localparam logic [FLASH_CNT_W-1:0] LOAD = FLASH_CNT_W'(FLASH_FRAMES);

  goal_state_t            state_n;
  logic [FLASH_CNT_W-1:0] cnt;
  logic [FLASH_CNT_W-1:0] cnt_n;
  logic                   side_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PLAY;
      cnt        <= '0;
      flash_side <= 1'b0;
      flashing   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      flash_side <= side_n;
      flashing   <= (state == FLASH);
    end
  end

  // A goal always (re)starts the flash, even on the boundary that would end it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    side_n  = flash_side;
    case (state)
      PLAY: begin
        if (goal_pulse) begin
          state_n = FLASH;
          cnt_n   = LOAD;
          side_n  = goal_side;
        end
      end
      FLASH: begin
        if (goal_pulse) begin
          cnt_n  = LOAD;
          side_n = goal_side;
        end else if (frame) begin
          if (cnt <= FLASH_CNT_W'(1)) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - FLASH_CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = PLAY;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong pixel generator: two-stage pipeline from raster counters to RGB, drawing border,
// serving line, paddles and ball from frame-latched positions, plus the goal flash.
module pong_renderer #(
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned H_OFFSET     = 144,
  parameter int unsigned V_OFFSET     = 35,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BORDER       = 10,
  parameter int unsigned PADDLE_LEN   = 50,
  parameter int unsigned PADDLE_THK   = 10,
  parameter int unsigned BALL_SIDE    = 10,
  parameter int unsigned FLASH_FRAMES = 30,
  parameter int unsigned BLINK_SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        h_cnt,
  input  logic [11:0]        v_cnt,
  input  logic               active,
  input  logic [11:0]        paddle_1,
  input  logic [11:0]        paddle_2,
  input  logic [11:0]        ball_x,
  input  logic [11:0]        ball_y,
  input  logic               serve,
  input  logic               goal_pulse,
  input  logic               goal_side,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               flashing
);

  import pong_pkg::*;

  localparam int unsigned CW = COORD_W;
  localparam logic [COLOR_W-1:0] CMAX = '1;

  localparam logic [CW-1:0] BORDER_L  = CW'(H_OFFSET + BORDER);
  localparam logic [CW-1:0] BORDER_R  = CW'(H_OFFSET + H_ACTIVE - BORDER - 1);
  localparam logic [CW-1:0] BORDER_T  = CW'(V_OFFSET + BORDER);
  localparam logic [CW-1:0] BORDER_B  = CW'(V_OFFSET + V_ACTIVE - BORDER - 1);
  localparam logic [CW-1:0] NET_LO    = CW'(H_OFFSET + H_ACTIVE/2 - BORDER/2);
  localparam logic [CW-1:0] NET_HI    = CW'(H_OFFSET + H_ACTIVE/2 + BORDER/2);
  localparam logic [CW-1:0] HALF_H    = CW'(H_OFFSET + H_ACTIVE/2);
  localparam logic [CW-1:0] LPAD_LO   = CW'(H_OFFSET + 4*BORDER);
  localparam logic [CW-1:0] LPAD_HI   = CW'(H_OFFSET + 4*BORDER + PADDLE_THK);
  localparam logic [CW-1:0] RPAD_HI   = CW'(H_OFFSET + H_ACTIVE - 1 - 4*BORDER);
  localparam logic [CW-1:0] RPAD_LO   = CW'(H_OFFSET + H_ACTIVE - 1 - 4*BORDER - PADDLE_THK);

  logic                   frame;
  positions_t             shadow;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [CW-1:0]          h;
  logic [CW-1:0]          v;
  logic [CW-1:0]          p1_top;
  logic [CW-1:0]          p2_top;
  logic [CW-1:0]          ball_l;
  logic [CW-1:0]          ball_t;
  logic                   border_hit;
  logic                   net_hit;
  logic                   lpad_hit;
  logic                   rpad_hit;
  logic                   ball_hit;
  logic                   blink_off;
  logic                   hit_q;
  logic                   active_q;
  logic                   left_q;
  goal_state_t            state;
  logic                   flash_side;
  logic                   flash_px;

  assign frame = (h_cnt == 12'd0) && (v_cnt == 12'd0);

  // Positions only move on frame boundaries so a frame is never drawn half old, half new.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      frame_cnt <= '0;
    end else if (frame) begin
      shadow    <= '{paddle_1: paddle_1, paddle_2: paddle_2, ball_x: ball_x, ball_y: ball_y};
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign h      = CW'(h_cnt);
  assign v      = CW'(v_cnt);
  assign p1_top = CW'(V_OFFSET) + CW'(shadow.paddle_1);
  assign p2_top = CW'(V_OFFSET) + CW'(shadow.paddle_2);
  assign ball_l = CW'(H_OFFSET) + CW'(shadow.ball_x);
  assign ball_t = CW'(V_OFFSET) + CW'(shadow.ball_y);

  assign border_hit = (h < BORDER_L) || (h > BORDER_R) || (v < BORDER_T) || (v > BORDER_B);
  assign net_hit    = (h > NET_LO) && (h < NET_HI);
  assign lpad_hit   = (h > LPAD_LO) && (h < LPAD_HI) &&
                      (v > p1_top) && (v < p1_top + CW'(PADDLE_LEN));
  assign rpad_hit   = (h > RPAD_LO) && (h < RPAD_HI) &&
                      (v > p2_top) && (v < p2_top + CW'(PADDLE_LEN));
  assign blink_off  = serve && frame_cnt[BLINK_SHIFT];
  assign ball_hit   = !blink_off &&
                      (h > ball_l) && (h < ball_l + CW'(BALL_SIDE)) &&
                      (v > ball_t) && (v < ball_t + CW'(BALL_SIDE));

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q    <= 1'b0;
      active_q <= 1'b0;
      left_q   <= 1'b0;
    end else begin
      hit_q    <= border_hit || net_hit || lpad_hit || rpad_hit || ball_hit;
      active_q <= active;
      left_q   <= (h < HALF_H);
    end
  end

  pong_goal_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_goal_fsm (
    .clk       (clk),
    .rst       (rst),
    .frame     (frame),
    .goal_pulse(goal_pulse),
    .goal_side (goal_side),
    .state     (state),
    .flash_side(flash_side),
    .flashing  (flashing)
  );

  assign flash_px = (state == FLASH) && (flash_side ? !left_q : left_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!active_q) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (hit_q) begin
      red   <= CMAX;
      green <= CMAX;
      blue  <= CMAX;
    end else begin
      red   <= flash_px ? CMAX : '0;
      green <= '0;
      blue  <= '0;
    end
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench for pong_renderer: directed scenarios plus randomized pixels
// compared against a frame-level behavioural model.
module tb_pong_renderer;

  localparam int HO = 144, VO = 35, HA = 640, VA = 480;
  localparam int B = 10, PL = 50, PT = 10, BS = 10, FF = 30, BSH = 3;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] h_cnt = '0, v_cnt = '0;
  logic        active = 1'b0;
  logic [11:0] paddle_1 = '0, paddle_2 = '0, ball_x = '0, ball_y = '0;
  logic        serve = 1'b0, goal_pulse = 1'b0, goal_side = 1'b0;
  logic [3:0]  red, green, blue;
  logic        flashing;

  int checks = 0;
  int errors = 0;

  // Model state: shadow positions, frame counter, flash frames remaining
  int m_p1 = 0, m_p2 = 0, m_bx = 0, m_by = 0, m_fc = 0;
  int m_flash = 0, m_left = 0, m_side = 0;
  int pend_r = 0, pend_g = 0, pend_b = 0, pend_f = 0;
  int exp_r = 0, exp_g = 0, exp_b = 0, exp_f = 0;

  always #5 clk = ~clk;

  pong_renderer dut (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .paddle_1  (paddle_1),
    .paddle_2  (paddle_2),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .serve     (serve),
    .goal_pulse(goal_pulse),
    .goal_side (goal_side),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .flashing  (flashing)
  );

  function automatic int m_hit(int h, int v, int srv);
    int border, net, lp, rp, ball;
    border = (h < HO + B) || (h > HO + HA - B - 1) || (v < VO + B) || (v > VO + VA - B - 1);
    net    = (h > HO + HA/2 - B/2) && (h < HO + HA/2 + B/2);
    lp     = (h > HO + 4*B) && (h < HO + 4*B + PT) && (v > VO + m_p1) && (v < VO + m_p1 + PL);
    rp     = (h > HO + HA - 1 - 4*B - PT) && (h < HO + HA - 1 - 4*B) &&
             (v > VO + m_p2) && (v < VO + m_p2 + PL);
    ball   = (h > HO + m_bx) && (h < HO + m_bx + BS) && (v > VO + m_by) && (v < VO + m_by + BS) &&
             !(srv != 0 && ((m_fc >> BSH) & 1) == 1);
    return (border || net || lp || rp || ball) ? 1 : 0;
  endfunction

  // One clock: advance the model, then expose what the DUT should show after this edge.
  task automatic tick();
    int h, v, hit, nr, ng, nb, nf;
    h = int'(h_cnt);
    v = int'(v_cnt);
    nr = 0; ng = 0; nb = 0; nf = 0;
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_bx = 0; m_by = 0; m_fc = 0;
      m_flash = 0; m_left = 0; m_side = 0;
    end else begin
      hit = m_hit(h, v, int'(serve));
      if (h == 0 && v == 0) begin
        m_p1 = int'(paddle_1); m_p2 = int'(paddle_2);
        m_bx = int'(ball_x);   m_by = int'(ball_y);
        m_fc = (m_fc + 1) % 256;
      end
      if (goal_pulse) begin
        m_flash = 1; m_left = FF; m_side = int'(goal_side);
      end else if (m_flash != 0 && h == 0 && v == 0) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          m_flash = 0; m_left = 0;
        end
      end
      if (active && hit != 0) begin
        nr = CMAX; ng = CMAX; nb = CMAX;
      end else if (active && m_flash != 0 && ((m_side == 0) == (h < HO + HA/2))) begin
        nr = CMAX;
      end
      nf = m_flash;
    end
    if (rst) begin
      exp_r = 0; exp_g = 0; exp_b = 0; exp_f = 0;
    end else begin
      exp_r = pend_r; exp_g = pend_g; exp_b = pend_b; exp_f = pend_f;
    end
    @(posedge clk);
    #1;
    pend_r = nr; pend_g = ng; pend_b = nb; pend_f = nf;
  endtask

  task automatic drive(int h, int v, logic act);
    h_cnt  = 12'(h);
    v_cnt  = 12'(v);
    active = act;
    tick();
  endtask

  task automatic pulse_goal(logic side);
    goal_pulse = 1'b1;
    goal_side  = side;
    drive(5, 5, 1'b0);
    goal_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(249, 140, 1'b1);
    checks++;
    if ({red, green, blue, flashing} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state rgbf=%h want 0", {red, green, blue, flashing});
    end
    rst = 1'b0;
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue, flashing} !== 13'd0) begin
      errors++;
      $display("FAIL reset_drain rgbf=%h want 0", {red, green, blue, flashing});
    end
  endtask

  task automatic test_ball();
    ball_x = 12'd100; ball_y = 12'd100; serve = 1'b0;
    drive(0, 0, 1'b0);
    drive(249, 140, 1'b1);
    drive(244, 140, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hfff || exp_r != CMAX) begin
      errors++;
      $display("FAIL ball_white rgb=%h want fff (model r=%0d)", {red, green, blue}, exp_r);
    end
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000 || exp_r != 0) begin
      errors++;
      $display("FAIL ball_edge_black rgb=%h want 000", {red, green, blue});
    end
  endtask

  task automatic test_shadow();
    ball_x = 12'd300;
    drive(249, 140, 1'b1);
    drive(249, 140, 1'b1);
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'hfff) begin
      errors++;
      $display("FAIL shadow_hold rgb=%h want fff", {red, green, blue});
    end
    drive(0, 0, 1'b0);
    drive(249, 140, 1'b1);
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL shadow_update rgb=%h want 000", {red, green, blue});
    end
    ball_x = 12'd100;
    drive(0, 0, 1'b0);
  endtask

  task automatic test_blink();
    int want;
    serve = 1'b1;
    for (int k = 0; k < 32; k++) begin
      drive(0, 0, 1'b0);
      drive(249, 140, 1'b1);
      drive(1, 1, 1'b0);
      want = (((m_fc >> BSH) & 1) == 0) ? CMAX : 0;
      checks++;
      if (int'(red) != want || int'(red) != exp_r || int'(blue) != exp_b) begin
        errors++;
        $display("FAIL serve_blink fc=%0d rgb=%h want r=%0d", m_fc, {red, green, blue}, want);
      end
    end
    serve = 1'b0;
  endtask

  task automatic test_flash();
    pulse_goal(1'b0);
    drive(200, 300, 1'b1);
    drive(600, 300, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hf00 || flashing !== 1'b1) begin
      errors++;
      $display("FAIL flash_left rgb=%h f=%b want f00 f=1", {red, green, blue}, flashing);
    end
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL flash_right_dark rgb=%h want 000", {red, green, blue});
    end
    for (int k = 1; k <= FF; k++) begin
      drive(0, 0, 1'b0);
      drive(1, 1, 1'b0);
      checks++;
      if (flashing !== logic'(k < FF) || int'(flashing) != exp_f) begin
        errors++;
        $display("FAIL flash_len boundary=%0d f=%b want %0d", k, flashing, (k < FF));
      end
    end
  endtask

  task automatic test_regoal();
    pulse_goal(1'b0);
    for (int k = 0; k < 20; k++) drive(0, 0, 1'b0);
    pulse_goal(1'b1);
    drive(600, 300, 1'b1);
    drive(200, 300, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hf00) begin
      errors++;
      $display("FAIL regoal_right rgb=%h want f00", {red, green, blue});
    end
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL regoal_left_dark rgb=%h want 000", {red, green, blue});
    end
    for (int k = 1; k <= FF; k++) begin
      drive(0, 0, 1'b0);
      drive(1, 1, 1'b0);
      checks++;
      if (flashing !== logic'(k < FF)) begin
        errors++;
        $display("FAIL regoal_len boundary=%0d f=%b want %0d", k, flashing, (k < FF));
      end
    end
    pulse_goal(1'b0);
    for (int k = 0; k < FF - 1; k++) drive(0, 0, 1'b0);
    goal_pulse = 1'b1;
    goal_side  = 1'b1;
    drive(0, 0, 1'b0);
    goal_pulse = 1'b0;
    drive(1, 1, 1'b0);
    drive(1, 1, 1'b0);
    checks++;
    if (flashing !== 1'b1 || exp_f != 1) begin
      errors++;
      $display("FAIL goal_on_expiry f=%b want 1", flashing);
    end
    for (int k = 0; k < FF; k++) drive(0, 0, 1'b0);
  endtask

  task automatic test_rst_mid();
    pulse_goal(1'b0);
    drive(249, 140, 1'b1);
    rst = 1'b1;
    goal_pulse = 1'b1;
    drive(249, 140, 1'b1);
    checks++;
    if ({red, green, blue, flashing} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid rgbf=%h want 0", {red, green, blue, flashing});
    end
    rst = 1'b0;
    goal_pulse = 1'b0;
    drive(200, 300, 1'b1);
    drive(1, 1, 1'b0);
    checks++;
    if ({red, green, blue, flashing} !== 13'd0) begin
      errors++;
      $display("FAIL rst_play rgbf=%h want 0", {red, green, blue, flashing});
    end
  endtask

  task automatic test_random();
    int h, v;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 399) == 0);
      goal_pulse = ($urandom_range(0, 96) == 0);
      goal_side  = 1'($urandom_range(0, 1));
      serve      = 1'($urandom_range(0, 1));
      paddle_1   = 12'($urandom_range(0, 450));
      paddle_2   = 12'($urandom_range(0, 450));
      ball_x     = 12'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 640));
      ball_y     = 12'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 480));
      case ($urandom_range(0, 3))
        0: begin h = HO + m_bx + $urandom_range(0, 11); v = VO + m_by + $urandom_range(0, 11); end
        1: begin h = HO + 4*B + $urandom_range(0, 11); v = VO + m_p1 + $urandom_range(0, 51); end
        default: begin h = $urandom_range(0, 799); v = $urandom_range(0, 524); end
      endcase
      if ($urandom_range(0, 39) == 0) begin h = 0; v = 0; end
      drive(h % 4096, v % 4096, 1'($urandom_range(0, 7) != 0));
      checks++;
      if (int'(red) != exp_r || int'(green) != exp_g || int'(blue) != exp_b ||
          int'(flashing) != exp_f) begin
        errors++;
        $display("FAIL random n=%0d rgbf=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                 n, red, green, blue, flashing, exp_r, exp_g, exp_b, exp_f);
      end
    end
    rst = 1'b0;
    goal_pulse = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ball();
    test_shadow();
    test_blink();
    test_flash();
    test_regoal();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
